// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state type, requester IDs and default widths for ram_arbiter_2x.
package ram_arb_pkg;
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/ram_arb_grant.sv
// ram_arb_grant: one-hot grant picker; on a tie the requester that was not granted last wins.
// A pointer held at REQ_FETCH gives fixed priority to the data requester.
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_rr_ptr,
  input  logic       i_idle,
  output logic [1:0] o_grant
);
  assign o_grant[1] = i_idle && i_valid1 && (!i_valid0 || i_rr_ptr == REQ_FETCH);
  assign o_grant[0] = i_idle && i_valid0 && !o_grant[1];
endmodule

// File: rtl/ram_arbiter_2x.sv
// ram_arbiter_2x: shares one single-port RAM between fetch (r0) and load/store (r1).
// RAM_ARB_RR_EN selects round-robin arbitration; otherwise the data requester has fixed priority.
module ram_arbiter_2x
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_data,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_data,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  state_t            r_state;
  logic              r_tag;
  logic              w_rr_ptr;
  logic              w_acc;
  logic              w_we;
  logic [1:0]        w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Readies are gated by reset so nothing looks accepted while rst_n is low.
  ram_arb_grant u_grant (
    .i_valid0 (r0_req_valid),
    .i_valid1 (r1_req_valid),
    .i_rr_ptr (w_rr_ptr),
    .i_idle   (r_state == IDLE && rst_n),
    .o_grant  (w_grant)
  );

  assign r0_req_ready = w_grant[0];
  assign r1_req_ready = w_grant[1];
  assign w_acc        = |w_grant;
  assign w_we         = w_grant[1] ? r1_we    : r0_we;
  assign w_addr       = w_grant[1] ? r1_addr  : r0_addr;
  assign w_wdata      = w_grant[1] ? r1_wdata : r0_wdata;
  assign r0_rsp_data  = ram_dout;
  assign r1_rsp_data  = ram_dout;

`ifdef RAM_ARB_RR_EN
  logic r_rr_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rr_ptr <= REQ_FETCH;
    else if (w_acc) r_rr_ptr <= w_grant[1];
  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = REQ_FETCH;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tag        <= REQ_FETCH;
      ram_read_en  <= 1'b0;
      ram_write_en <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
    end else if (r_state == ISSUE) begin
      r_state      <= IDLE;
      ram_read_en  <= 1'b0;
      ram_write_en <= 1'b0;
      r0_rsp_valid <= ram_read_en && r_tag == REQ_FETCH;
      r1_rsp_valid <= ram_read_en && r_tag == REQ_DATA;
    end else begin
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      if (w_acc) begin
        r_state      <= ISSUE;
        r_tag        <= w_grant[1];
        ram_read_en  <= !w_we;
        ram_write_en <= w_we;
        ram_addr     <= w_addr;
        ram_din      <= w_wdata;
      end
    end
endmodule

// File: tb/tb_ram_arbiter_2x.sv
// tb_ram_arbiter_2x: directed and randomized checks of ram_arbiter_2x against a transaction-level model.
module tb_ram_arbiter_2x;
  localparam int AW = 10;
  localparam int DW = 16;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit v;
    bit we;
    bit id;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic ram_re, ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di, ram_do;
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] exp_mem [int];
  logic [AW-1:0] pool [6] = '{10'h010, 10'h020, 10'h3FF, 10'h005, 10'h1A5, 10'h000};
  bit m_last = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_a] <= ram_di;
    if (ram_re) ram_do <= ram[ram_a];
  end

  ram_arbiter_2x dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(v0), .r0_req_ready(rdy0), .r0_we(we0), .r0_addr(a0), .r0_wdata(d0),
    .r0_rsp_valid(rv0), .r0_rsp_data(rd0),
    .r1_req_valid(v1), .r1_req_ready(rdy1), .r1_we(we1), .r1_addr(a1), .r1_wdata(d1),
    .r1_rsp_valid(rv1), .r1_rsp_data(rd1),
    .ram_read_en(ram_re), .ram_write_en(ram_we), .ram_addr(ram_a), .ram_din(ram_di),
    .ram_dout(ram_do)
  );

  task automatic issue(input bit id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output bit acc, output logic re_o, output logic we_o,
                       output logic [AW-1:0] a_o, output logic [DW-1:0] d_o,
                       output logic rv0_o, output logic rv1_o, output logic [DW-1:0] rd_o);
    acc = 1'b0;
    if (id) begin v1 = 1'b1; we1 = we; a1 = a; d1 = d; end
    else begin v0 = 1'b1; we0 = we; a0 = a; d0 = d; end
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = id ? rdy1 : rdy0;
      if (!acc) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    if (id) v1 = 1'b0; else v0 = 1'b0;
    if (acc) begin m_last = id; if (we) exp_mem[int'(a)] = d; end
    @(negedge clk);
    re_o = ram_re; we_o = ram_we; a_o = ram_a; d_o = ram_di;
    @(posedge clk); #1;
    @(negedge clk);
    rv0_o = rv0; rv1_o = rv1; rd_o = id ? rd1 : rd0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; we0 = 1'b0; we1 = 1'b0; a0 = 10'h001; a1 = 10'h002;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({ram_re, ram_we} !== 2'b00) begin failures++; $display("FAIL reset_en got=%b exp=00", {ram_re, ram_we}); end
    checks++; if (ram_a !== '0 || ram_di !== '0) begin failures++; $display("FAIL reset_addr_din got=%h/%h exp=0/0", ram_a, ram_di); end
    checks++; if ({rdy0, rdy1} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {rdy0, rdy1}); end
    checks++; if ({rv0, rv1} !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b exp=00", {rv0, rv1}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({rdy1, rdy0} !== 2'b10) begin failures++; $display("FAIL reset_first_grant got=%b exp=10", {rdy1, rdy0}); end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0; m_last = 1'b1;
    @(negedge clk);
    checks++; if (ram_re !== 1'b1 || ram_a !== 10'h002) begin failures++; $display("FAIL reset_first_issue got=%b/%h exp=1/002", ram_re, ram_a); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    bit acc; logic re, we, r0v, r1v; logic [AW-1:0] a; logic [DW-1:0] d, rd;
    issue(1'b0, 1'b1, 10'h3FF, 16'hBEEF, acc, re, we, a, d, r0v, r1v, rd);
    checks++; if (!acc) begin failures++; $display("FAIL wr_accept got=0 exp=1"); end
    checks++; if ({re, we} !== 2'b01) begin failures++; $display("FAIL wr_enables got=%b exp=01", {re, we}); end
    checks++; if (a !== 10'h3FF || d !== 16'hBEEF) begin failures++; $display("FAIL wr_addr_din got=%h/%h exp=3ff/beef", a, d); end
    checks++; if ({r0v, r1v} !== 2'b00) begin failures++; $display("FAIL wr_no_rsp got=%b exp=00", {r0v, r1v}); end
    issue(1'b0, 1'b0, 10'h3FF, 16'h0000, acc, re, we, a, d, r0v, r1v, rd);
    checks++; if ({re, we} !== 2'b10 || a !== 10'h3FF) begin failures++; $display("FAIL rd_enables got=%b/%h exp=10/3ff", {re, we}, a); end
    checks++; if ({r0v, r1v} !== 2'b10) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=10", {r0v, r1v}); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=beef", rd); end
    @(negedge clk);
    checks++; if ({rv0, rv1} !== 2'b00) begin failures++; $display("FAIL rd_rsp_pulse got=%b exp=00", {rv0, rv1}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bit acc; logic re, we, r0v, r1v; logic [AW-1:0] a; logic [DW-1:0] d, rd;
    issue(1'b1, 1'b1, 10'h005, 16'h1234, acc, re, we, a, d, r0v, r1v, rd);
    v1 = 1'b1; we1 = 1'b0; a1 = 10'h005;
    @(negedge clk);
    checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL b2b_r1_ready got=%b exp=1", rdy1); end
    @(posedge clk); #1;
    v1 = 1'b0; v0 = 1'b1; we0 = 1'b1; a0 = 10'h005; d0 = 16'h5678;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL b2b_issue_ready got=%b exp=0", rdy0); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rv1 !== 1'b1 || rd1 !== 16'h1234) begin failures++; $display("FAIL b2b_old_data got=%b/%h exp=1/1234", rv1, rd1); end
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL b2b_r0_ready got=%b exp=1", rdy0); end
    @(posedge clk); #1;
    v0 = 1'b0; exp_mem[5] = 16'h5678; m_last = 1'b0;
    @(negedge clk);
    checks++; if (ram_we !== 1'b1 || ram_di !== 16'h5678 || rv1 !== 1'b0) begin failures++; $display("FAIL b2b_write got=%b/%h/%b exp=1/5678/0", ram_we, ram_di, rv1); end
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 10'h005, 16'h0000, acc, re, we, a, d, r0v, r1v, rd);
    checks++; if (r1v !== 1'b1 || rd !== 16'h5678) begin failures++; $display("FAIL b2b_new_data got=%b/%h exp=1/5678", r1v, rd); end
  endtask

  task automatic test_reset_mid;
    bit acc; logic re, we, r0v, r1v; logic [AW-1:0] a; logic [DW-1:0] d, rd;
    v0 = 1'b1; we0 = 1'b0; a0 = 10'h3FF;
    @(negedge clk);
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    checks++; if (ram_re !== 1'b1) begin failures++; $display("FAIL mid_read_en got=%b exp=1", ram_re); end
    rst_n = 1'b0;
    #1;
    checks++; if (ram_re !== 1'b0) begin failures++; $display("FAIL mid_async_drop got=%b exp=0", ram_re); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({rv0, rv1} !== 2'b00) begin failures++; $display("FAIL mid_rsp_lost got=%b exp=00", {rv0, rv1}); end
    @(posedge clk); #1;
    rst_n = 1'b1; m_last = 1'b0;
    @(negedge clk);
    checks++; if ({rv0, rv1} !== 2'b00) begin failures++; $display("FAIL mid_rsp_after got=%b exp=00", {rv0, rv1}); end
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 10'h3FF, 16'h0000, acc, re, we, a, d, r0v, r1v, rd);
    checks++; if (!acc || r0v !== 1'b1 || rd !== 16'hBEEF) begin failures++; $display("FAIL mid_recover got=%b/%b/%h exp=1/1/beef", acc, r0v, rd); end
  endtask

  // Model: one accept per two cycles, tie goes to r1 (fixed) or to the requester not granted last (RR);
  // reads return the memory image as of their accept.
  task automatic test_traffic(input int n, input bit rnd);
    bit acc; logic re, we, r0v, r1v; logic [AW-1:0] a; logic [DW-1:0] d, rd;
    txn_t p1, p2;
    int free_at;
    int acc_cnt [2];
    bit e0, e1;
    for (int i = 0; i < 6; i++)
      issue(1'(i), 1'b1, pool[i], 16'($urandom), acc, re, we, a, d, r0v, r1v, rd);
    p1 = '{v: 1'b0, we: 1'b0, id: 1'b0, a: '0, d: '0};
    p2 = p1;
    free_at = 0;
    acc_cnt = '{0, 0};
    for (int c = 0; c < n + 8; c++) begin
      if (rnd) begin
        v0 = c < n && 1'($urandom); v1 = c < n && 1'($urandom);
        we0 = 1'($urandom); we1 = 1'($urandom);
        a0 = pool[$urandom_range(5, 0)]; a1 = pool[$urandom_range(5, 0)];
        d0 = 16'($urandom); d1 = 16'($urandom);
      end else begin
        v1 = c < n; v0 = c < n + 4;
        we0 = 1'b0; we1 = 1'b0; a0 = 10'h010; a1 = 10'h020;
      end
      @(negedge clk);
      e0 = 1'b0; e1 = 1'b0;
      if (c >= free_at) begin
        if (v1 && (!v0 || !(RR && m_last))) e1 = 1'b1;
        else if (v0) e0 = 1'b1;
      end
      checks++; if ({rdy1, rdy0} !== {e1, e0}) begin failures++; $display("FAIL traffic_grant c=%0d got=%b exp=%b", c, {rdy1, rdy0}, {e1, e0}); end
      checks++; if ({ram_re, ram_we} !== {p1.v && !p1.we, p1.v && p1.we}) begin failures++; $display("FAIL traffic_enable c=%0d got=%b exp=%b", c, {ram_re, ram_we}, {p1.v && !p1.we, p1.v && p1.we}); end
      if (p1.v) begin
        checks++; if (ram_a !== p1.a || (p1.we && ram_di !== p1.d)) begin failures++; $display("FAIL traffic_addr c=%0d got=%h/%h exp=%h/%h", c, ram_a, ram_di, p1.a, p1.d); end
      end
      checks++; if ({rv1, rv0} !== {p2.v && !p2.we && p2.id, p2.v && !p2.we && !p2.id}) begin failures++; $display("FAIL traffic_rsp c=%0d got=%b exp=%b", c, {rv1, rv0}, {p2.v && !p2.we && p2.id, p2.v && !p2.we && !p2.id}); end
      if (p2.v && !p2.we) begin
        checks++; if ((p2.id ? rd1 : rd0) !== p2.d) begin failures++; $display("FAIL traffic_data c=%0d got=%h exp=%h", c, p2.id ? rd1 : rd0, p2.d); end
      end
      p2 = p1;
      p1.v = e0 || e1; p1.id = e1;
      p1.we = e1 ? we1 : we0; p1.a = e1 ? a1 : a0;
      if (p1.v) begin
        p1.d = p1.we ? (e1 ? d1 : d0) : exp_mem[int'(p1.a)];
        if (p1.we) exp_mem[int'(p1.a)] = p1.d;
        m_last = p1.id; free_at = c + 2; acc_cnt[p1.id]++;
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0; v1 = 1'b0;
    if (!rnd) begin
      checks++; if (acc_cnt[0] == 0) begin failures++; $display("FAIL traffic_r0_served got=0 exp>0"); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_traffic(12, 1'b0);
    test_traffic(400, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_arbiter_2x.md
Name: ram_arbiter_2x

Overview:
Shares the single-port 16x1024 CPU RAM between two requesters: requester 0 (instruction fetch) and requester 1 (load/store).
- Accepts one request per grant using a valid/ready handshake.
- Drives the RAM's read_en/write_en/addr/din from registers.
- Returns read data with a one-cycle rsp_valid pulse to the requester that issued the read.
- Sits between the CPU front-end/LSU and the RAM instance.

Parameters:
ADDR_W, 10, RAM address width (1024 words)
DATA_W, 16, RAM data width

Ports:
clk  in  1  clock
rst_n  in  1  reset
r0_req_valid  in  1  requester 0 request present
r0_req_ready  out  1  requester 0 request accepted this cycle when valid also high
r0_we  in  1  1=write, 0=read
r0_addr  in  ADDR_W  word address
r0_wdata  in  DATA_W  write data
r0_rsp_valid  out  1  one-cycle pulse, read data valid
r0_rsp_data  out  DATA_W  read data
r1_req_valid, r1_req_ready, r1_we, r1_addr, r1_wdata, r1_rsp_valid, r1_rsp_data: same as r0 for requester 1
ram_read_en  out  1  to RAM read_en
ram_write_en  out  1  to RAM write_en
ram_addr  out  ADDR_W  to RAM addr
ram_din  out  DATA_W  to RAM din
ram_dout  in  DATA_W  from RAM dout (registered in RAM, holds until next read)

Behaviour:
Interface:
- Reset rst_n: asynchronous, active-low. Clock clk.
- While reset is asserted: state=IDLE; ram_read_en=0, ram_write_en=0, ram_addr=0, ram_din=0; both rsp_valid=0; rr pointer=0.

State machine:
- IDLE: readies are combinational from state and grant; only the winner's ready=1. If any req_valid is high, accept the winner, register enable/addr/din, go to ISSUE.
- ISSUE: both readies=0. Exactly one of ram_read_en/ram_write_en=1 for this cycle. Next state is IDLE.
- The enables are cleared on the IDLE transition, so an enable is high for exactly one cycle per accepted request.
- ram_read_en and ram_write_en are never high in the same cycle.

Arbitration (fixed priority, default):
- Requester 1 (data) wins when both are valid in IDLE.

Latency:
- Request accepted in cycle N (valid & ready).
- RAM enable high in cycle N+1.
- For reads, rx_rsp_valid=1 in cycle N+2 only, for the issuing requester only.
- rx_rsp_data is wired to ram_dout for both requesters; it is valid only while that requester's rsp_valid=1.
- Writes produce no response.

Throughput:
- At most one accept per 2 cycles.
- A new accept in cycle N+2 is legal; it does not disturb ram_dout before cycle N+4.

Boundary conditions:
- Requester fields are sampled only at accept. Changes while not ready are ignored.
- Dropping valid before ready is allowed, and nothing is issued for it.
- Read and write to the same address back-to-back: the read issued after the write returns the new data.
- Reset mid-ISSUE: the enable deasserts immediately and any pending rsp_valid is lost. The RAM contents for that write are undefined.
- A pending response tag (1 bit, which requester) is held from accept until rsp_valid.

Optional Feature:
Macro RAM_ARB_RR_EN.
- Defined: round-robin arbitration. The 1-bit pointer records the last granted requester. On a tie the other requester wins. The pointer updates only on accept and resets to 0, so requester 1 wins the first tie.
- Undefined: fixed priority, requester 1 wins. The pointer logic is absent.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, ISSUE}
  - requester ID constants REQ_FETCH=0, REQ_DATA=1
  - default ADDR_W/DATA_W localparams
- Sub-module ram_arb_grant: combinational picker. Inputs: two valids, the rr pointer, the IDLE flag. Outputs: one-hot grant. Holds the RAM_ARB_RR_EN variant.

Test Plan:
1. Reset: hold rst_n=0 with both valids high -> all RAM outputs 0, both readies 0, no rsp_valid. After release, the first accept occurs in the first IDLE cycle.
2. Write then read: r0 writes 0xBEEF to addr 0x3FF, then reads 0x3FF -> ram_write_en one cycle with addr=0x3FF, din=0xBEEF. For the read, r0_rsp_valid=1 exactly 2 cycles after accept with data 0xBEEF; r1_rsp_valid stays 0.
3. Contention, fixed priority: r0 reads 0x010 and r1 reads 0x020, both valid continuously -> r1 is granted on every accept while it stays valid. r0 is accepted only after r1 drops valid.
4. Contention with RAM_ARB_RR_EN: same stimulus as 3 -> grants alternate r1,r0,r1,r0. Each rsp_valid goes to the correct requester with the data of its own address.
5. Back-to-back: r1 reads addr 5 (preloaded 0x1234), then r0 writes addr 5 with 0x5678 accepted in the same cycle r1's rsp_valid=1 -> r1 receives 0x1234. A subsequent read of addr 5 returns 0x5678.
6. Reset mid-ISSUE: assert rst_n=0 in the cycle ram_read_en=1 -> enable drops immediately, no rsp_valid follows, state returns to IDLE.
